// File: rtl/opcode_dispatch_pkg.sv
// Shared types for the opcode dispatch controller.
// Build option: define DISPATCH_TRACE_EN for simulation response tracing.
package opcode_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    DISPATCH = 3'd2,
    WAIT     = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam logic OP_DISPATCH = 1'b0;
  localparam logic OP_INVALID  = 1'b1;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_INVALID = 2'd2
  } status_t;

endpackage

// File: rtl/dispatch_timer.sv
// Clear/enable 8-bit wait counter; expire flags the final wait cycle.
// Counting stops at expiry, so the counter never wraps.
module dispatch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/opcode_dispatch_ctrl.sv
// Decodes one command at a time, launches a unit and returns its status.
// Build option: DISPATCH_TRACE_EN prints a line at every response entry.
module opcode_dispatch_ctrl
  import opcode_dispatch_pkg::*;
#(
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_opcode,
  input  logic [ID_W-1:0]      cmd_id,
  output logic [2**ID_W-1:0]   unit_start,
  input  logic [2**ID_W-1:0]   unit_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_status,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  localparam int NUM_UNITS = 2**ID_W;
  localparam logic [NUM_UNITS-1:0] ONE = NUM_UNITS'(1);

  state_t          state;
  state_t          state_n;
  status_t         status_q;
  status_t         status_n;
  logic            op_q;
  logic [ID_W-1:0] id_q;
  logic            done_hit;
  logic            expire;

  assign done_hit = unit_done[id_q];

  dispatch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (state == DISPATCH),
    .enable(state == WAIT),
    .expire(expire)
  );

  always_comb begin
    state_n  = state;
    status_n = status_q;
    unique case (state)
      IDLE: begin
        if (cmd_valid) state_n = DECODE;
      end
      DECODE: begin
        if (op_q == OP_DISPATCH) begin
          state_n = DISPATCH;
        end else begin
          state_n  = RESP;
          status_n = ST_INVALID;
        end
      end
      DISPATCH: state_n = WAIT;
      WAIT: begin
        // done is checked first so it beats a same-cycle expiry
        if (done_hit) begin
          state_n  = RESP;
          status_n = ST_OK;
        end else if (expire) begin
          state_n  = RESP;
          status_n = ST_TIMEOUT;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      status_q <= ST_OK;
      op_q     <= OP_DISPATCH;
      id_q     <= '0;
    end else begin
      state    <= state_n;
      status_q <= status_n;
      if (state == IDLE && cmd_valid) begin
        op_q <= cmd_opcode;
        id_q <= cmd_id;
      end
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);
  assign rsp_status = status_q;
  assign rsp_id     = id_q;
  assign unit_start = (state == DISPATCH) ? (ONE << id_q) : '0;

`ifdef DISPATCH_TRACE_EN
  always_ff @(posedge clock) begin
    if (!reset && state != RESP && state_n == RESP) begin
      if (status_n == ST_OK)
        $display("id %0d ok", id_q);
      else if (status_n == ST_TIMEOUT)
        $display("id %0d timeout", id_q);
      else
        $display("invalid");
    end
  end
`endif

endmodule
